dgen_rot_uni: RTL

- Deterministic unipolar bitstream transmitter (binary-to-stochastic encoder).
- Accepts a pair of DATAWD-bit operands via valid/ready handshake.
- Emits two rotated unipolar bitstreams of 2^(2*DATAWD) beats; the AND of the two streams over the full run has popcount exactly A*B.
- Feeds downstream stochastic compute units (AND multipliers, counters/decoders) with backpressure support.

---
 rtl/dgen_rot_uni.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dgen_rot_uni.sv
// Rotated unipolar bitstream encoder: two comparator streams whose
// AND over the full run carries exactly A*B ones.
module dgen_rot_uni #(
  parameter int DATAWD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATAWD-1:0] iA,
  input  logic [DATAWD-1:0] iB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bitA,
  output logic              bitB,
  output logic              last,
  output logic              busy
);

  localparam logic [DATAWD-1:0]   CMAX = '1;
  localparam logic [2*DATAWD-1:0] BMAX = '1;

  typedef enum logic {IDLE, RUN} st_t;

  st_t state_q, state_d;

  logic [DATAWD-1:0]   a_q, a_d;
  logic [DATAWD-1:0]   b_q, b_d;
  logic [DATAWD-1:0]   ca_q, ca_d;
  logic [DATAWD-1:0]   cb_q, cb_d;
  logic [2*DATAWD-1:0] bc_q, bc_d;
  logic                bita_q, bita_d;
  logic                bitb_q, bitb_d;
  logic                last_q, last_d;

  logic take;
  logic acc;

  assign take = in_valid & (state_q == IDLE);
  assign acc  = out_ready & (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (out_ready && last_q) state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == RUN);
    busy      = (state_q != IDLE);
  end

  // Output bits are registered from the counter values of the next beat.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    ca_d   = ca_q;
    cb_d   = cb_q;
    bc_d   = bc_q;
    bita_d = bita_q;
    bitb_d = bitb_q;
    last_d = last_q;
    if (take) begin
      a_d    = iA;
      b_d    = iB;
      ca_d   = '0;
      cb_d   = '0;
      bc_d   = '0;
      bita_d = (iA > '0);
      bitb_d = (iB > '0);
      last_d = 1'b0;
    end else if (acc) begin
      if (last_q) begin
        bita_d = 1'b0;
        bitb_d = 1'b0;
        last_d = 1'b0;
      end else begin
        ca_d   = ca_q + 1'b1;
        // B holds once per A period, rotating its phase.
        cb_d   = (ca_q == CMAX) ? cb_q : cb_q + 1'b1;
        bc_d   = bc_q + 1'b1;
        bita_d = (a_q > ca_d);
        bitb_d = (b_q > cb_d);
        last_d = (bc_d == BMAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ca_q   <= '0;
      cb_q   <= '0;
      bc_q   <= '0;
      bita_q <= 1'b0;
      bitb_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      ca_q   <= ca_d;
      cb_q   <= cb_d;
      bc_q   <= bc_d;
      bita_q <= bita_d;
      bitb_q <= bitb_d;
      last_q <= last_d;
    end
  end

  assign bitA = bita_q;
  assign bitB = bitb_q;
  assign last = last_q;

endmodule
